// File: rtl/uart_key_pkg.sv
// uart_key_pkg: shared definitions for the UART key decoder.
//   - key index names and the byte code each key responds to
//   - ESC code that drops every held key
//   - decoder FSM state encoding
//   - fold_byte(): optional upper->lower case fold applied before matching
package uart_key_pkg;

  // Key indices; only indices below the decoder's N_KEYS are live.
  typedef enum int unsigned {
    KEY_ATTACK = 0,  // space
    KEY_UP     = 1,  // 'w'
    KEY_LEFT   = 2,  // 'a'
    KEY_RIGHT  = 3,  // 'd'
    KEY_DOWN   = 4,  // 's'
    KEY_E      = 5,  // 'e'
    KEY_Q      = 6,  // 'q'
    KEY_ENTER  = 7   // CR
  } key_idx_e;

  localparam int unsigned MAX_KEYS = 8;

  // Packed code table, element [i] is the code of key index i.
  localparam logic [MAX_KEYS-1:0][7:0] KEY_CODES = {
    8'h0D,  // 7 CR
    8'h71,  // 6 'q'
    8'h65,  // 5 'e'
    8'h73,  // 4 's'
    8'h64,  // 3 'd'
    8'h61,  // 2 'a'
    8'h77,  // 1 'w'
    8'h20   // 0 space
  };

  localparam logic [7:0] ESC_CODE = 8'h1B;

  // Decoder FSM encoding.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_DECODE = 1'b1;

  function automatic logic [7:0] key_code(input int unsigned idx);
    logic [2:0] sel;
    sel = idx[2:0];
    return KEY_CODES[sel];
  endfunction

  // Only 'A'..'Z' fold, so ESC and CR pass through untouched.
  function automatic logic [7:0] fold_byte(input logic [7:0] b, input logic fold_en);
    if (fold_en && (b >= 8'h41) && (b <= 8'h5A)) return b + 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/uart_key_decoder_if.sv
// uart_key_decoder_if: receive-FIFO read port (first-word-fall-through).
//   empty     : FIFO empty flag, uart_data valid whenever empty=0
//   uart_data : head byte of the FIFO
//   rd_uart   : one-cycle pop strobe from the consumer
// master = FIFO side, slave = decoder side.
interface uart_key_decoder_if;
  logic       empty;
  logic [7:0] uart_data;
  logic       rd_uart;

  modport master (output empty, output uart_data, input  rd_uart);
  modport slave  (input  empty, input  uart_data, output rd_uart);
endinterface

// File: rtl/uart_key_hold.sv
// uart_key_hold: per-key hold timer.
//   clk, rst : clock, async active-high reset
//   load     : restart the hold window at HOLD_CYCLES
//   clear    : drop the key immediately (wins over load)
//   active   : high while the counter is non-zero
module uart_key_hold #(
  parameter int HOLD_CYCLES = 4_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic active
);

  localparam int W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (clear)      cnt <= '0;
    else if (load)       cnt <= LOAD_VAL;
    else if (cnt != '0)  cnt <= cnt - 1'b1;  // saturates at zero
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/uart_key_decoder.sv
// uart_key_decoder: pops bytes from a FWFT receive FIFO and turns them into
// held key outputs.
//   clk, rst  : clock, async active-high reset
//   fifo      : FIFO read port (empty, uart_data in; rd_uart out)
//   btn       : N_KEYS held key outputs, each high HOLD_CYCLES after its
//               last matching byte
//   err       : one-cycle pulse per unrecognised byte
// A byte seen in IDLE is latched and popped; the following DECODE cycle
// matches it, so outputs move two cycles after empty falls and at most one
// byte is accepted every two cycles.
module uart_key_decoder
  import uart_key_pkg::*;
#(
  parameter int N_KEYS      = 5,
  parameter int HOLD_CYCLES = 4_000_000,
  parameter int CASE_FOLD   = 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_key_decoder_if.slave   fifo,
  output logic [N_KEYS-1:0]   btn,
  output logic                err
);

  logic [0:0]        state_q;
  logic [7:0]        byte_q;
  logic              rd_q;
  logic              err_q;

  logic              decode;
  logic [7:0]        code;
  logic              esc;
  logic              unknown;
  logic [N_KEYS-1:0] hit;

  assign decode  = (state_q == ST_DECODE);
  assign code    = fold_byte(byte_q, CASE_FOLD != 0);
  assign esc     = decode && (code == ESC_CODE);
  assign unknown = decode && !esc && (hit == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      byte_q  <= 8'h00;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rd_q  <= 1'b0;
      err_q <= unknown;
      case (state_q)
        ST_IDLE: begin
          if (!fifo.empty) begin
            state_q <= ST_DECODE;
            byte_q  <= fifo.uart_data;
            rd_q    <= 1'b1;  // high exactly for the DECODE cycle
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    assign hit[i] = decode && (code == key_code(i));

    uart_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
      .clk    (clk),
      .rst    (rst),
      .load   (hit[i]),
      .clear  (esc),
      .active (btn[i])
    );
  end

  assign fifo.rd_uart = rd_q;
  assign err          = err_q;

endmodule
